// File: rtl/int_to_fp_arb.sv
// Two-requester round-robin front end feeding a shift-normalising 8-bit integer
// to 13-bit {sign, exp[3:0], frac[7:0]} floating-point converter.
module int_to_fp_arb (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [7:0]  integ0,
   input  logic        req1,
   input  logic [7:0]  integ1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        busy,
   output logic        done_tick,
   output logic        done_id,
   output logic [12:0] fp
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t            state, state_nxt;
   logic              last_id;
   logic              sel_id;
   logic              grant;
   logic              norm_end;
   logic signed [7:0] operand;
   logic              sign;
   logic              id;
   logic [3:0]        expo;
   logic [7:0]        mag;

   // Magnitude in 9 bits so that -128 maps cleanly onto 8'h80.
   function automatic logic [7:0] abs8(input logic signed [7:0] v);
      logic signed [8:0] w;
      w = 9'(v);
      return (w < 0) ? 8'(-w) : 8'(w);
   endfunction

   always_comb begin
      sel_id    = (req0 && req1) ? ~last_id : req1;
      grant     = (state == IDLE) && (req0 || req1) && !reset;
      operand   = sel_id ? $signed(integ1) : $signed(integ0);
      norm_end  = (state == NORM) && ((mag == 8'd0) || mag[7]);
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = NORM;
         NORM:    if (norm_end) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign gnt0      = grant && !sel_id;
   assign gnt1      = grant && sel_id;
   assign busy      = (state != IDLE);
   assign done_tick = (state == DONE);

   // fp is loaded as NORM finishes so it is already valid while done_tick is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         last_id <= 1'b1;
         fp      <= 13'h0000;
         done_id <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) last_id <= sel_id;
         if (norm_end) begin
            fp      <= (mag == 8'd0) ? 13'h0000 : {sign, expo, mag};
            done_id <= id;
         end
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (grant) begin
            sign <= operand[7];
            mag  <= abs8(operand);
            expo <= 4'd8;
            id   <= sel_id;
         end
         NORM: if (mag == 8'd0) begin
            sign <= 1'b0;
            expo <= 4'd0;
         end else if (!mag[7]) begin
            mag  <= mag << 1;
            expo <= expo - 4'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_int_to_fp_arb.sv
// Directed and exhaustive-sweep bench for int_to_fp_arb.
module tb_int_to_fp_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [7:0]  integ0, integ1;
   logic        gnt0, gnt1, busy, done_tick, done_id;
   logic [12:0] fp;
   int          n_cmp = 0;
   int          n_bad = 0;

   int_to_fp_arb dut (
      .clk(clk), .reset(reset),
      .req0(req0), .integ0(integ0), .req1(req1), .integ1(integ1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .done_tick(done_tick), .done_id(done_id), .fp(fp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Returns {k[3:0], fp[12:0]} for an 8-bit two's complement input.
   function automatic logic [16:0] model(input logic [7:0] v);
      int s, m, k;
      logic [7:0] f;
      s = $signed(v);
      m = (s < 0) ? -s : s;
      if (m == 0) return 17'd0;
      k = 0;
      while (((m << k) & 128) == 0) k++;
      f = 8'((m << k) & 255);
      return {4'(k), (s < 0), 4'(8 - k), f};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst_fp", fp, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_done_tick", done_tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt0, gnt1}, 0);
      reset = 1'b0;
   endtask

   task automatic conv(input bit id, input logic [7:0] v, input logic [12:0] efp, input int ecyc);
      int cyc;
      bit got;
      if (id) begin integ1 = v; req1 = 1'b1; end
      else    begin integ0 = v; req0 = 1'b1; end
      #1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (gnt0 || gnt1) begin got = 1; break; end
         @(negedge clk); #1;
      end
      chk("grant_seen", got, 1);
      chk("gnt0", gnt0, !id);
      chk("gnt1", gnt1, id);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("gnt_pulse", {gnt0, gnt1}, 0);
      cyc = 1; got = 0;
      while (cyc <= 12) begin
         chk("busy", busy, 1);
         if (done_tick) begin got = 1; break; end
         @(negedge clk); #1;
         cyc++;
      end
      chk("done_seen", got, 1);
      chk("latency", cyc, ecyc);
      chk("fp", fp, efp);
      chk("done_id", done_id, id);
      @(negedge clk); #1;
      chk("idle_after", {busy, done_tick}, 0);
      chk("fp_hold", fp, efp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] m;
      int cyc;
      bit got;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; integ0 = 8'h00; integ1 = 8'h00;
      @(negedge clk);
      do_reset();

      conv(1'b0, 8'h01, 13'b0_0001_10000000, 9);
      conv(1'b1, 8'h80, 13'b1_1000_10000000, 2);
      conv(1'b0, 8'hFD, 13'b1_0010_11000000, 8);
      conv(1'b0, 8'h7F, 13'b0_0111_11111110, 3);
      conv(1'b0, 8'h00, 13'h0000, 2);

      // Both requests held from reset: strict alternation, one IDLE cycle between.
      do_reset();
      integ0 = 8'h00; integ1 = 8'h40; req0 = 1'b1; req1 = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("rr_gnt0", gnt0, (g % 2) == 0);
         chk("rr_gnt1", gnt1, (g % 2) == 1);
         got = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (done_tick) begin got = 1; break; end
         end
         chk("rr_done_seen", got, 1);
         chk("rr_done_id", done_id, g % 2);
         chk("rr_fp", fp, (g % 2) ? 13'b0_0111_10000000 : 13'h0000);
         if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
         @(negedge clk); #1;
      end
      chk("rr_idle", busy, 0);

      // Asynchronous reset in the middle of a long normalisation.
      integ0 = 8'h01; req0 = 1'b1;
      #1;
      chk("ab_gnt0", gnt0, 1);
      @(negedge clk); req0 = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      #1;
      chk("ab_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("ab_busy", busy, 0);
      chk("ab_done_tick", done_tick, 0);
      chk("ab_fp", fp, 0);
      chk("ab_done_id", done_id, 0);
      chk("ab_gnt", {gnt0, gnt1}, 0);
      @(negedge clk); #1;
      reset = 1'b0;
      got = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (done_tick || busy) got = 1;
      end
      chk("ab_no_done", got, 0);
      integ1 = 8'h05; req0 = 1'b1; req1 = 1'b1;
      #1;
      chk("ab_tie_gnt0", gnt0, 1);
      chk("ab_tie_gnt1", gnt1, 0);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);
      #1;

      for (int v = 0; v < 256; v++) begin
         m = model(v[7:0]);
         cyc = 2 + int'(m[16:13]);
         conv(1'b0, v[7:0], m[12:0], cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
